// File: rtl/instr_realign_buf_pkg.sv
// Shared types and helpers for the RV32IC fetch realignment buffer.
// Optional feature macro used by the block: REALIGN_ILLEGAL_DETECT_EN.
package rv_realign_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    UPPER = 2'd2
  } realign_state_t;

  localparam logic [1:0] OPC_32BIT = 2'b11;

  // A halfword starts a compressed instruction unless its low two bits are 11.
  function automatic logic is_comp(input logic [15:0] hw);
    return hw[1:0] != OPC_32BIT;
  endfunction

endpackage

// File: rtl/instr_realign_buf_if.sv
// Fetch-side and decoder-side handshake bundle for instr_realign_buf.
// REALIGN_ILLEGAL_DETECT_EN adds the instr_illegal flag.
interface instr_realign_buf_if;

  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        flush;
  logic [31:0] flush_pc;

  logic [31:0] instr_data;
  logic        instr_is_comp;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

`ifdef REALIGN_ILLEGAL_DETECT_EN
  logic        instr_illegal;

  modport slave (
    input  fetch_data, fetch_valid, flush, flush_pc, instr_ready,
    output fetch_ready, instr_data, instr_is_comp, instr_pc, instr_valid, instr_illegal
  );

  modport master (
    output fetch_data, fetch_valid, flush, flush_pc, instr_ready,
    input  fetch_ready, instr_data, instr_is_comp, instr_pc, instr_valid, instr_illegal
  );
`else
  modport slave (
    input  fetch_data, fetch_valid, flush, flush_pc, instr_ready,
    output fetch_ready, instr_data, instr_is_comp, instr_pc, instr_valid
  );

  modport master (
    output fetch_data, fetch_valid, flush, flush_pc, instr_ready,
    input  fetch_ready, instr_data, instr_is_comp, instr_pc, instr_valid
  );
`endif

endinterface

// File: rtl/instr_realign_buf.sv
// Realigns word-aligned fetch data into one RV32IC instruction per cycle.
// Define REALIGN_ILLEGAL_DETECT_EN to flag the all-zero compressed encoding.
module instr_realign_buf
  import rv_realign_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                aclk,
  input  logic                aresetn,
  instr_realign_buf_if.slave  bus
);

  realign_state_t state_reg, state_next;
  logic [31:0]    word_reg, word_next;
  logic [15:0]    hw_buf_reg, hw_buf_next;
  logic [31:0]    pc_reg, pc_next;
  logic           skip_lo_reg, skip_lo_next;

  logic           emit;
  logic           fetch_xfer;
  logic [31:0]    flush_target;

  assign emit         = bus.instr_valid & bus.instr_ready;
  assign fetch_xfer   = bus.fetch_valid & bus.fetch_ready;
  assign flush_target = bus.flush_pc & ~32'd1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg   <= EMPTY;
      word_reg    <= '0;
      hw_buf_reg  <= '0;
      pc_reg      <= RESET_PC;
      skip_lo_reg <= RESET_PC[1];
    end else begin
      state_reg   <= state_next;
      word_reg    <= word_next;
      hw_buf_reg  <= hw_buf_next;
      pc_reg      <= pc_next;
      skip_lo_reg <= skip_lo_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    word_next    = word_reg;
    hw_buf_next  = hw_buf_reg;
    pc_next      = pc_reg;
    skip_lo_next = skip_lo_reg;

    if (emit) begin
      pc_next = pc_reg + (bus.instr_is_comp ? 32'd2 : 32'd4);
    end

    unique case (state_reg)
      EMPTY: begin
        if (fetch_xfer) begin
          skip_lo_next = 1'b0;
          if (skip_lo_reg) begin
            hw_buf_next = bus.fetch_data[31:16];
            state_next  = UPPER;
          end else begin
            word_next  = bus.fetch_data;
            state_next = FULL;
          end
        end
      end
      FULL: begin
        if (emit) begin
          if (is_comp(word_reg[15:0])) begin
            hw_buf_next = word_reg[31:16];
            state_next  = UPPER;
          end else if (fetch_xfer) begin
            word_next = bus.fetch_data;
          end else begin
            state_next = EMPTY;
          end
        end
      end
      UPPER: begin
        if (emit) begin
          if (is_comp(hw_buf_reg)) begin
            if (fetch_xfer) begin
              word_next  = bus.fetch_data;
              state_next = FULL;
            end else begin
              state_next = EMPTY;
            end
          end else begin
            // Straddle consumed: the new word's upper half becomes the carry.
            hw_buf_next = bus.fetch_data[31:16];
          end
        end
      end
      default: state_next = EMPTY;
    endcase

    if (bus.flush) begin
      state_next   = EMPTY;
      pc_next      = flush_target;
      skip_lo_next = bus.flush_pc[1];
    end
  end

  // instr_valid never looks at instr_ready; fetch_ready may.
  always_comb begin
    bus.instr_valid   = 1'b0;
    bus.instr_data    = '0;
    bus.instr_is_comp = 1'b0;
    bus.instr_pc      = pc_reg;
    bus.fetch_ready   = 1'b0;

    unique case (state_reg)
      EMPTY: begin
        bus.fetch_ready = 1'b1;
      end
      FULL: begin
        bus.instr_valid = 1'b1;
        if (is_comp(word_reg[15:0])) begin
          bus.instr_data    = {16'h0000, word_reg[15:0]};
          bus.instr_is_comp = 1'b1;
        end else begin
          bus.instr_data  = word_reg;
          bus.fetch_ready = bus.instr_ready;
        end
      end
      UPPER: begin
        bus.fetch_ready = bus.instr_ready;
        if (is_comp(hw_buf_reg)) begin
          bus.instr_valid   = 1'b1;
          bus.instr_data    = {16'h0000, hw_buf_reg};
          bus.instr_is_comp = 1'b1;
        end else begin
          bus.instr_valid = bus.fetch_valid;
          bus.instr_data  = {bus.fetch_data[15:0], hw_buf_reg};
        end
      end
      default: ;
    endcase

    if (bus.flush) begin
      bus.instr_valid = 1'b0;
      bus.fetch_ready = 1'b0;
    end
  end

`ifdef REALIGN_ILLEGAL_DETECT_EN
  assign bus.instr_illegal = bus.instr_valid & bus.instr_is_comp &
                             (bus.instr_data[15:0] == 16'h0000);
`endif

endmodule

// File: tb/tb_instr_realign_buf.sv
// Scoreboard bench for instr_realign_buf: a halfword-stream model predicts every emitted instruction.
// Checks instr_illegal as well when REALIGN_ILLEGAL_DETECT_EN is defined.
module tb_instr_realign_buf;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] data;
    logic        comp;
    logic [31:0] pc;
  } exp_t;

  logic aclk;
  logic aresetn;
  instr_realign_buf_if bus();

  instr_realign_buf #(.RESET_PC(RESET_PC)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int   vectors     = 0;
  int   miscompares = 0;

  exp_t expq[$];
  int   flush_mark = 0;
  int   rd_idx     = 0;

  // Reference model: the fetched bytes form a halfword stream; instructions are cut from its head.
  initial begin
    logic [15:0] hwq[$];
    logic [31:0] mpc;
    logic        mskip;
    bit          more;
    mpc   = RESET_PC;
    mskip = RESET_PC[1];
    forever begin
      @(negedge aclk or negedge aresetn);
      if (!aresetn) begin
        hwq.delete();
        mpc        = RESET_PC;
        mskip      = RESET_PC[1];
        flush_mark = expq.size();
      end else if (bus.flush) begin
        hwq.delete();
        mpc        = bus.flush_pc & ~32'd1;
        mskip      = bus.flush_pc[1];
        flush_mark = expq.size();
      end else if (bus.fetch_valid && bus.fetch_ready) begin
        if (!mskip) hwq.push_back(bus.fetch_data[15:0]);
        hwq.push_back(bus.fetch_data[31:16]);
        mskip = 1'b0;
        more  = 1'b1;
        while (more && hwq.size() > 0) begin
          if (hwq[0][1:0] != 2'b11) begin
            expq.push_back('{data: {16'h0000, hwq[0]}, comp: 1'b1, pc: mpc});
            mpc = mpc + 32'd2;
            void'(hwq.pop_front());
          end else if (hwq.size() >= 2) begin
            expq.push_back('{data: {hwq[1], hwq[0]}, comp: 1'b0, pc: mpc});
            mpc = mpc + 32'd4;
            void'(hwq.pop_front());
            void'(hwq.pop_front());
          end else begin
            more = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: compares every emit against the scoreboard and checks stability under backpressure.
  initial begin
    exp_t        e;
    bit          prev_stall;
    logic [31:0] p_data, p_pc;
    logic        p_comp;
    prev_stall = 1'b0;
    forever begin
      @(negedge aclk);
      #1;
      if (rd_idx < flush_mark) rd_idx = flush_mark;
      if (!aresetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !bus.flush) begin
          vectors++;
          if (!(bus.instr_valid === 1'b1 && bus.instr_data === p_data &&
                bus.instr_pc === p_pc && bus.instr_is_comp === p_comp)) begin
            miscompares++;
            $display("FAIL hold_stable: got v=%b d=%h pc=%h c=%b, need v=1 d=%h pc=%h c=%b",
                     bus.instr_valid, bus.instr_data, bus.instr_pc, bus.instr_is_comp,
                     p_data, p_pc, p_comp);
          end
        end
        if (bus.instr_valid && bus.instr_ready) begin
          vectors++;
          if (rd_idx >= expq.size()) begin
            miscompares++;
            $display("FAIL unexpected_emit: got d=%h pc=%h, none expected",
                     bus.instr_data, bus.instr_pc);
          end else begin
            e = expq[rd_idx];
            rd_idx++;
            $display("emit pc=%h data=%h comp=%b", bus.instr_pc, bus.instr_data, bus.instr_is_comp);
            if (bus.instr_data !== e.data || bus.instr_pc !== e.pc || bus.instr_is_comp !== e.comp) begin
              miscompares++;
              $display("FAIL emit: got d=%h pc=%h c=%b, need d=%h pc=%h c=%b",
                       bus.instr_data, bus.instr_pc, bus.instr_is_comp, e.data, e.pc, e.comp);
            end
`ifdef REALIGN_ILLEGAL_DETECT_EN
            vectors++;
            if (bus.instr_illegal !== (e.comp && e.data[15:0] == 16'h0000)) begin
              miscompares++;
              $display("FAIL illegal_flag: got %b for d=%h", bus.instr_illegal, e.data);
            end
`endif
          end
        end
        prev_stall = bus.instr_valid && !bus.instr_ready;
        p_data     = bus.instr_data;
        p_pc       = bus.instr_pc;
        p_comp     = bus.instr_is_comp;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    vectors++;
    if (got !== need) begin
      miscompares++;
      $display("FAIL %s: got %h, need %h", name, got, need);
    end
  endtask

  // Holds the current fetch word until a transfer is seen, bounded.
  task automatic wait_accept();
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge aclk);
      if (bus.fetch_ready && !bus.flush) done = 1'b1;
      @(posedge aclk);
      #1;
    end
    bus.fetch_valid = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL fetch_accept: got no transfer in 50 cycles, need one");
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    @(posedge aclk);
    #1;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = w;
    wait_accept();
  endtask

  task automatic do_flush(input logic [31:0] target);
    @(posedge aclk);
    #1;
    bus.flush    = 1'b1;
    bus.flush_pc = target;
    @(posedge aclk);
    #1;
    bus.flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h   = 16'($urandom);
    int          sel = $urandom_range(0, 9);
    if (sel < 4) h[1:0] = 2'b11;
    else if (sel == 9) h = 16'h0000;
    else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
    return h;
  endfunction

  initial begin
    bit pending;
    aresetn         = 1'b0;
    bus.fetch_data  = '0;
    bus.fetch_valid = 1'b0;
    bus.flush       = 1'b0;
    bus.flush_pc    = '0;
    bus.instr_ready = 1'b0;
    #22;
    aresetn = 1'b1;
    #1;
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_pc", bus.instr_pc, RESET_PC);
    check("rst_data", bus.instr_data, 32'd0);
    check("rst_comp", 32'(bus.instr_is_comp), 32'd0);
    check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);

    // Compressed pairs, a full-word addi, then a straddling 32-bit instruction.
    bus.instr_ready = 1'b1;
    send_word(32'h4501_4581);
    send_word(32'h0000_4601);
    idle(4);
    send_word(32'h00A0_0093);
    idle(3);
    send_word(32'h0093_4581);
    send_word(32'h0001_00A0);
    idle(4);

    // Redirect to an upper halfword: the low half of the next word is dropped.
    do_flush(32'h0000_0102);
    send_word(32'h4505_0001);
    idle(3);

    // Backpressure on a FULL compressed pair with a second word waiting.
    bus.instr_ready = 1'b0;
    send_word(32'h4501_4581);
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h4603_4602;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bp_fetch_ready", 32'(bus.fetch_ready), 32'd0);
      check("bp_valid", 32'(bus.instr_valid), 32'd1);
      @(posedge aclk);
      #1;
    end
    bus.instr_ready = 1'b1;
    wait_accept();
    idle(5);

    // PC wraps past the top of the address space.
    do_flush(32'hFFFF_FFFF);
    send_word(32'h4501_4581);
    send_word(32'h4583_4582);
    idle(4);

    // Asynchronous reset while a straddle is presented and stalled.
    do_flush(32'h0000_0000);
    send_word(32'h0093_4581);
    idle(3);
    check("upper_pc", bus.instr_pc, 32'h0000_0002);
    bus.instr_ready = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h0001_00A0;
    @(negedge aclk);
    check("straddle_valid", 32'(bus.instr_valid), 32'd1);
    check("straddle_data", bus.instr_data, 32'h00A0_0093);
    @(posedge aclk);
    #2;
    aresetn         = 1'b0;
    bus.fetch_valid = 1'b0;
    #1;
    check("arst_valid", 32'(bus.instr_valid), 32'd0);
    check("arst_pc", bus.instr_pc, RESET_PC);
    check("arst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    @(negedge aclk);
    @(posedge aclk);
    #3;
    aresetn = 1'b1;
    idle(1);

    // Randomized traffic with backpressure and occasional redirects.
    pending = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge aclk);
      #1;
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      bus.flush       = ($urandom_range(0, 40) == 0);
      bus.flush_pc    = $urandom;
      if (!pending) begin
        bus.fetch_valid = ($urandom_range(0, 2) != 0);
        bus.fetch_data  = {rand_hw(), rand_hw()};
      end
      @(negedge aclk);
      pending = bus.fetch_valid && !bus.fetch_ready && !bus.flush;
    end

    @(posedge aclk);
    #1;
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.instr_ready = 1'b1;
    idle(20);
    check("drain_outstanding", 32'(expq.size() - rd_idx), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
